// File: rtl/tick_sched_if.sv
// tick_sched_if: divisor-reprogramming handshake for tick_sched.
//   cfg_valid  master->slave  new divisor offered
//   cfg_div    master->slave  divisor value, tick period = cfg_div+1
//   cfg_ready  slave->master  controller can accept a divisor
// A transfer happens on a rising clock edge where cfg_valid && cfg_ready.
interface tick_sched_if #(
    parameter int WIDTH = 16
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/tick_sched.sv
// tick_sched: tick scheduler for the clock-divider datapath.
//   A runtime-programmable prescaler produces a base tick. Each base tick is a
//   slot boundary; slots are served round-robin (fixed TDM) and the served slot
//   gets a one-cycle enable pulse on tick_o if it was requesting.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         run(1)/stop(0)
//   req        per-slot request, sampled on that slot's boundary
//   cfg        tick_sched_if.slave divisor handshake (cfg_valid/cfg_div/cfg_ready)
//   base_tick  one-cycle pulse per prescaler wrap
//   tick_o     one-hot one-cycle grant pulse (or all zero)
//   slot       slot the next boundary serves
//   tick_cnt   (only with TICK_SCHED_CNT_EN) base tick counter, cleared by a
//              config transfer
// Optional feature macro: TICK_SCHED_CNT_EN
module tick_sched #(
    parameter int WIDTH   = 16,
    parameter int NCH     = 4,
    parameter int DIV_RST = 15,
    parameter int OFFSET  = 0,
    localparam int SW     = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   req,
    tick_sched_if.slave      cfg,
    output logic             base_tick,
    output logic [NCH-1:0]   tick_o,
    output logic [SW-1:0]    slot
`ifdef TICK_SCHED_CNT_EN
    ,
    output logic [15:0]      tick_cnt
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] pend_div;
    logic             pend;
    logic             boundary;
    logic             xfer;

    // ">=" rather than "==" so a reset phase offset beyond the divisor (or a
    // divisor lowered below the running count) still wraps instead of running
    // off to 2^WIDTH.
    assign boundary = (cnt >= div_q);
    assign xfer     = cfg.cfg_valid && cfg.cfg_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= WIDTH'(OFFSET);
            div_q         <= WIDTH'(DIV_RST);
            pend_div      <= '0;
            pend          <= 1'b0;
            slot          <= '0;
            base_tick     <= 1'b0;
            tick_o        <= '0;
            cfg.cfg_ready <= 1'b1;
        end else begin
            base_tick <= 1'b0;
            tick_o    <= '0;

            // pend=1 always implies cfg_ready=0, so a transfer never collides
            // with a pending divisor. Ready reopens once nothing is pending;
            // in IDLE that lands one cycle after the divisor is applied.
            if (xfer) begin
                pend_div      <= cfg.cfg_div;
                pend          <= 1'b1;
                cfg.cfg_ready <= 1'b0;
            end else if (!pend && !cfg.cfg_ready) begin
                cfg.cfg_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pend) begin
                        div_q <= pend_div;
                        pend  <= 1'b0;
                    end
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (boundary) begin
                        cnt          <= '0;
                        base_tick    <= 1'b1;
                        tick_o[slot] <= req[slot];
                        // Non-requesting slots are consumed, keeping fixed TDM.
                        slot         <= (slot == SW'(NCH-1)) ? '0 : slot + 1'b1;
                        // Uses the registered pend, so a transfer landing on
                        // this same edge waits for the following boundary.
                        if (pend) begin
                            div_q         <= pend_div;
                            pend          <= 1'b0;
                            cfg.cfg_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // Stopping overrides the count but not the pulses above.
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TICK_SCHED_CNT_EN
    // Counts in step with base_tick (same edge it rises), so it can only move
    // while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        tick_cnt <= '0;
        else if (xfer)                   tick_cnt <= '0;
        else if (state == RUN && boundary) tick_cnt <= tick_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_tick_sched.sv
module tb_tick_sched;
    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       base_tick;
    logic [3:0] tick_o;
    logic [1:0] slot;
`ifdef TICK_SCHED_CNT_EN
    logic [15:0] tick_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int c;

    tick_sched_if #(.WIDTH(16)) cfg_if ();

    tick_sched #(.WIDTH(16), .NCH(4), .DIV_RST(15), .OFFSET(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .cfg       (cfg_if),
        .base_tick (base_tick),
        .tick_o    (tick_o),
        .slot      (slot)
`ifdef TICK_SCHED_CNT_EN
        ,
        .tick_cnt  (tick_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Steps negedges until base_tick is seen; returns the cycle count (bounded).
    task automatic next_pulse(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!base_tick && cyc < 300);
    endtask

    task automatic cfg_send(input logic [15:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = d;
    endtask

    initial begin
        logic [3:0] rot1 [4];
        logic [3:0] rot5 [4];
        rot1 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot5 = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};

        rst = 1'b1; en = 1'b0; req = 4'b1111;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_base", base_tick, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_slot", slot, 0);
        chk("rst_ready", cfg_if.cfg_ready, 1);

        // 1: default divisor, all slots requesting
        rst = 1'b1;
        @(negedge clk);
        en = 1'b1;
        next_pulse(c);
        chk("t1_first_lat", c, 17);
        chk("t1_first_tick", tick_o, 4'b0001);
        chk("t1_slot", slot, 1);
        for (int i = 0; i < 4; i++) begin
            next_pulse(c);
            chk("t1_period", c, 16);
            chk("t1_rot", tick_o, rot1[i]);
        end

        // 3: mid-period transfer, current period unaffected
        repeat (4) @(negedge clk);
        cfg_send(16'd3);
        @(negedge clk);
        chk("t3_ready_lo", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1'b0;
        next_pulse(c);
        chk("t3_old_period", c, 11);
        chk("t3_tick", tick_o, 4'b0010);
        chk("t3_ready_hi", cfg_if.cfg_ready, 1);
        next_pulse(c);
        chk("t3_new_period", c, 4);
        chk("t3_tick2", tick_o, 4'b0100);

        // 2: sparse requests, silent slots still consumed
        req = 4'b0101;
        next_pulse(c);
        chk("t2_period", c, 4);
        chk("t2_slot3", tick_o, 4'b0000);
        chk("t2_slot_wrap", slot, 0);
        next_pulse(c);
        chk("t2_slot0", tick_o, 4'b0001);
        next_pulse(c);
        chk("t2_slot1", tick_o, 4'b0000);
        next_pulse(c);
        chk("t2_slot2", tick_o, 4'b0100);
        chk("t2_slot_nxt", slot, 3);

        // 4: transfer on the boundary edge applies one boundary later
        repeat (3) @(negedge clk);
        cfg_send(16'd7);
        @(negedge clk);
        chk("t4_bnd_base", base_tick, 1);
        chk("t4_ready_lo", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1'b0;
        next_pulse(c);
        chk("t4_still_old", c, 4);
        chk("t4_ready_hi", cfg_if.cfg_ready, 1);
        next_pulse(c);
        chk("t4_new_period", c, 8);

        // 5: divisor 0 -> continuous base tick, rotating grant
        req = 4'b1111;
        cfg_send(16'd0);
        @(negedge clk);
        chk("t5_ready_lo", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1'b0;
        next_pulse(c);
        chk("t5_last_long", c, 7);
        chk("t5_tick", tick_o, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_base_hi", base_tick, 1);
            chk("t5_rot", tick_o, rot5[i]);
        end
        en = 1'b0;
        @(negedge clk);
        chk("t5_final_base", base_tick, 1);
        chk("t5_final_tick", tick_o, 4'b1000);
        @(negedge clk);
        chk("t5_idle_base", base_tick, 0);
        chk("t5_idle_tick", tick_o, 0);
        chk("t5_idle_slot", slot, 0);
        repeat (3) @(negedge clk);
        chk("t5_idle_hold", base_tick, 0);

        // 4b: IDLE transfer, ready back two cycles after
        cfg_send(16'd5);
        @(negedge clk);
        chk("t4i_ready_0", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1'b0;
        @(negedge clk);
        chk("t4i_ready_1", cfg_if.cfg_ready, 0);
        @(negedge clk);
        chk("t4i_ready_2", cfg_if.cfg_ready, 1);
        en = 1'b1;
        next_pulse(c);
        chk("t4i_first_lat", c, 7);
        chk("t4i_tick", tick_o, 4'b0001);
        next_pulse(c);
        chk("t4i_period", c, 6);

        // 6: async reset mid-period with a pending divisor
        repeat (2) @(negedge clk);
        cfg_send(16'd2);
        @(negedge clk);
        chk("t6_ready_lo", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_ready", cfg_if.cfg_ready, 1);
        chk("t6_async_slot", slot, 0);
        chk("t6_async_base", base_tick, 0);
        chk("t6_async_tick", tick_o, 0);
`ifdef TICK_SCHED_CNT_EN
        chk("t6_cnt_rst", tick_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        next_pulse(c);
        chk("t6_pend_gone", c, 17);
        chk("t6_tick", tick_o, 4'b0001);
`ifdef TICK_SCHED_CNT_EN
        chk("t6_cnt1", tick_cnt, 1);
`endif
        next_pulse(c);
        chk("t6_period", c, 16);
`ifdef TICK_SCHED_CNT_EN
        chk("t6_cnt2", tick_cnt, 2);
        next_pulse(c);
        chk("t6_cnt3", tick_cnt, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
